amf_stream_filter: RTL

- Sequential, handshaked successor to the combinational 3x3 approximate median filter (cf).
- Collects a 9-sample window serially over a valid/ready stream and runs a 2-stage registered min/med/max network.
- Emits one filtered result per window, selected by a per-window mode.
- Sits between a pixel/sample source and downstream image or signal processing.

---
 rtl/amf_stream_filter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/amf_stream_filter.sv
// -----------------------------------------------------------------------------
// amf_stream_filter
//
// Streaming 3x3 approximate median / min / max / centre filter. Nine samples
// (i0..i8, row-major) are collected one per accepted input beat, then a
// two-stage registered min/med/max network produces one result per window.
// The mode presented with i0 selects what that window's result is.
//
// Handshake: a beat moves on a rising clk edge where valid && ready. The
// producer holds valid/data until ready; ready never depends on valid.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   flush      drop a partially collected window (only acts while collecting)
//   mode       0=approx median, 1=min, 2=max, 3=centre pass-through
//   s_valid    input sample valid
//   s_ready    block accepts a sample this cycle
//   s_data     input sample
//   m_valid    result valid
//   m_ready    downstream accepts result
//   m_data     filtered result
//   m_mode     mode used for this result
//   busy       high whenever not idle in COLLECT with an empty window
//   dbg_state  current FSM state (0=COLLECT,1=STAGE1,2=STAGE2,3=OUTPUT)
// -----------------------------------------------------------------------------
module amf_stream_filter #(
    parameter int DATA_W = 8,
    parameter int MODE_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [MODE_W-1:0] mode,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [MODE_W-1:0] m_mode,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_STAGE1  = 2'd1;
    localparam logic [1:0] ST_STAGE2  = 2'd2;
    localparam logic [1:0] ST_OUTPUT  = 2'd3;

    localparam logic [MODE_W-1:0] MODE_MED    = MODE_W'(0);
    localparam logic [MODE_W-1:0] MODE_MIN    = MODE_W'(1);
    localparam logic [MODE_W-1:0] MODE_MAX    = MODE_W'(2);

    logic [1:0]                  r_state;
    logic [3:0]                  r_count;
    logic [8:0][DATA_W-1:0]      r_win;
    logic [MODE_W-1:0]           r_mode;
    logic [2:0][DATA_W-1:0]      r_row_min;
    logic [2:0][DATA_W-1:0]      r_row_med;
    logic [2:0][DATA_W-1:0]      r_row_max;
    logic [DATA_W-1:0]           r_centre;
    logic                        r_m_valid;
    logic [DATA_W-1:0]           r_m_data;
    logic [MODE_W-1:0]           r_m_mode;

    logic [2:0][DATA_W-1:0]      w_row_min;
    logic [2:0][DATA_W-1:0]      w_row_med;
    logic [2:0][DATA_W-1:0]      w_row_max;
    logic [DATA_W-1:0]           w_result;
    logic                        w_accept;

    function automatic logic [DATA_W-1:0] f_min(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] f_max(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // max(min(a,b), min(max(a,b),c)): exact median of three, ties collapse
    // onto equal values so the result does not depend on input order.
    function automatic logic [DATA_W-1:0] f_med3(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [DATA_W-1:0] c);
        return f_max(f_min(a, b), f_min(f_max(a, b), c));
    endfunction

    assign w_accept  = (r_state == ST_COLLECT) && s_valid && !flush;

    assign s_ready   = (r_state == ST_COLLECT);
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_mode    = r_m_mode;
    assign busy      = (r_state != ST_COLLECT) || (r_count != 4'd0);
    assign dbg_state = r_state;

    // First network stage: per-row statistics over samples 3r..3r+2.
    always_comb begin
        w_row_min = '0;
        w_row_med = '0;
        w_row_max = '0;
        w_row_min[0] = f_min(f_min(r_win[0], r_win[1]), r_win[2]);
        w_row_med[0] = f_med3(r_win[0], r_win[1], r_win[2]);
        w_row_max[0] = f_max(f_max(r_win[0], r_win[1]), r_win[2]);
        w_row_min[1] = f_min(f_min(r_win[3], r_win[4]), r_win[5]);
        w_row_med[1] = f_med3(r_win[3], r_win[4], r_win[5]);
        w_row_max[1] = f_max(f_max(r_win[3], r_win[4]), r_win[5]);
        w_row_min[2] = f_min(f_min(r_win[6], r_win[7]), r_win[8]);
        w_row_med[2] = f_med3(r_win[6], r_win[7], r_win[8]);
        w_row_max[2] = f_max(f_max(r_win[6], r_win[7]), r_win[8]);
    end

    // Second network stage: combine the row statistics per the latched mode.
    always_comb begin
        w_result = r_centre;
        case (r_mode)
            MODE_MED: w_result = f_med3(r_row_med[0], r_row_med[1], r_row_med[2]);
            MODE_MIN: w_result = f_min(f_min(r_row_min[0], r_row_min[1]), r_row_min[2]);
            MODE_MAX: w_result = f_max(f_max(r_row_max[0], r_row_max[1]), r_row_max[2]);
            default:  w_result = r_centre;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_COLLECT;
            r_count   <= 4'd0;
            r_win     <= '0;
            r_mode    <= '0;
            r_row_min <= '0;
            r_row_med <= '0;
            r_row_max <= '0;
            r_centre  <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_mode  <= '0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    // flush takes priority over a sample offered in the same cycle
                    if (flush) begin
                        r_count <= 4'd0;
                    end else if (w_accept) begin
                        r_win[r_count] <= s_data;
                        // mode is captured only with the first sample of a window
                        if (r_count == 4'd0) begin
                            r_mode <= mode;
                        end
                        if (r_count == 4'd8) begin
                            r_count <= 4'd0;
                            r_state <= ST_STAGE1;
                        end else begin
                            r_count <= r_count + 4'd1;
                        end
                    end
                end
                ST_STAGE1: begin
                    r_row_min <= w_row_min;
                    r_row_med <= w_row_med;
                    r_row_max <= w_row_max;
                    r_centre  <= r_win[4];
                    r_state   <= ST_STAGE2;
                end
                ST_STAGE2: begin
                    r_m_data  <= w_result;
                    r_m_mode  <= r_mode;
                    r_m_valid <= 1'b1;
                    r_state   <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    // result holds until taken; no new window starts meanwhile
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= ST_COLLECT;
                    end
                end
                default: begin
                    r_state <= ST_COLLECT;
                end
            endcase
        end
    end

endmodule
